// File: rtl/thiele_logic_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : thiele_logic_bridge
//  Description : Bridges a CPU logic-engine request (req/ack) onto an external
//                solver (valid/ready request, strobed response), with a
//                request timeout that returns an error word instead of hanging.
//  Revision    : 1.0 - initial release
// ============================================================================
module thiele_logic_bridge #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_req,
    input  logic [31:0] logic_addr,
    output logic        logic_ack,
    output logic [31:0] logic_data,
    output logic        sol_valid,
    output logic [31:0] sol_addr,
    input  logic        sol_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [31:0] req_count,
    output logic [15:0] timeout_count
);

    // Timer only needs to reach TIMEOUT_CYCLES-1.
    localparam int c_TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_ack;
    logic [31:0]            r_logic_data;
    logic                   r_sol_valid;
    logic [31:0]            r_sol_addr;
    logic                   r_busy;
    logic                   r_timeout_err;
    logic [31:0]            r_req_count;
    logic [15:0]            r_timeout_count;

    logic                   w_timer_expired;

    assign w_timer_expired = (r_timer == c_TIMER_LAST);

    // Request sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_timer         <= '0;
            r_ack           <= 1'b0;
            r_logic_data    <= 32'd0;
            r_sol_valid     <= 1'b0;
            r_sol_addr      <= 32'd0;
            r_busy          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_req_count     <= 32'd0;
            r_timeout_count <= 16'd0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (logic_req) begin
                        r_sol_addr  <= logic_addr;
                        r_timer     <= '0;
                        r_req_count <= r_req_count + 32'd1;
                        r_sol_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // No response can exist yet, so expiry always wins here.
                    if (w_timer_expired) begin
                        r_logic_data  <= ERR_DATA;
                        r_timeout_err <= 1'b1;
                        if (r_timeout_count != 16'hFFFF) begin
                            r_timeout_count <= r_timeout_count + 16'd1;
                        end
                        r_sol_valid   <= 1'b0;
                        r_timer       <= '0;
                        r_ack         <= 1'b1;
                        r_state       <= S_ACK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (sol_ready) begin
                            r_sol_valid <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (rsp_valid) begin
                        r_logic_data <= rsp_data;
                        r_timer      <= '0;
                        r_ack        <= 1'b1;
                        r_state      <= S_ACK;
                    end else if (w_timer_expired) begin
                        r_logic_data  <= ERR_DATA;
                        r_timeout_err <= 1'b1;
                        if (r_timeout_count != 16'hFFFF) begin
                            r_timeout_count <= r_timeout_count + 16'd1;
                        end
                        r_timer       <= '0;
                        r_ack         <= 1'b1;
                        r_state       <= S_ACK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Wait for the CPU to release the request so it is not re-serviced.
                    if (!logic_req) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_sol_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign logic_ack     = r_ack;
    assign logic_data    = r_logic_data;
    assign sol_valid     = r_sol_valid;
    assign sol_addr      = r_sol_addr;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;
    assign req_count     = r_req_count;
    assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_thiele_logic_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_thiele_logic_bridge
//  Description : Self-checking bench for thiele_logic_bridge: directed
//                scenarios with literal expectations plus randomized CPU and
//                solver traffic compared every cycle against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thiele_logic_bridge;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        logic_req = 1'b0;
    logic [31:0] logic_addr = 32'd0;
    logic        logic_ack;
    logic [31:0] logic_data;
    logic        sol_valid;
    logic [31:0] sol_addr;
    logic        sol_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        busy;
    logic        timeout_err;
    logic [31:0] req_count;
    logic [15:0] timeout_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    thiele_logic_bridge #(
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .logic_req     (logic_req),
        .logic_addr    (logic_addr),
        .logic_ack     (logic_ack),
        .logic_data    (logic_data),
        .sol_valid     (sol_valid),
        .sol_addr      (sol_addr),
        .sol_ready     (sol_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .req_count     (req_count),
        .timeout_count (timeout_count)
    );

    // ---------------- reference model ----------------
    // Phase of the current transaction; a request expires at an absolute
    // clock-edge index (deadline) fixed when it is accepted.
    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_ISSUE = 3'd1;
    localparam logic [2:0] P_WAIT  = 3'd2;
    localparam logic [2:0] P_ACK   = 3'd3;
    localparam logic [2:0] P_DRAIN = 3'd4;

    typedef struct packed {
        logic [2:0]  phase;
        logic [63:0] deadline;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] reqc;
        logic [15:0] toc;
        logic        terr;
    } model_t;

    model_t      m;
    logic [63:0] cyc = 64'd0;

    function automatic model_t model_next(input model_t cur, input logic rn, input logic req,
                                          input logic [31:0] addr, input logic rdy,
                                          input logic rv, input logic [31:0] rd,
                                          input logic [63:0] now);
        model_t n = cur;
        if (!rn) begin
            n = '0;
            return n;
        end
        case (cur.phase)
            P_IDLE: if (req) begin
                n.addr     = addr;
                n.reqc     = cur.reqc + 32'd1;
                n.deadline = now + 64'(T);
                n.phase    = P_ISSUE;
            end
            P_ISSUE, P_WAIT: begin
                if (cur.phase == P_WAIT && rv) begin
                    n.data  = rd;
                    n.phase = P_ACK;
                end else if (now == cur.deadline) begin
                    n.data  = ERR;
                    n.terr  = 1'b1;
                    n.toc   = (cur.toc == 16'hFFFF) ? cur.toc : cur.toc + 16'd1;
                    n.phase = P_ACK;
                end else if (cur.phase == P_ISSUE && rdy) begin
                    n.phase = P_WAIT;
                end
            end
            P_ACK:   n.phase = P_DRAIN;
            P_DRAIN: if (!req) n.phase = P_IDLE;
            default: n.phase = P_IDLE;
        endcase
        return n;
    endfunction

    // Advance the model on each rising edge with the inputs the DUT sees.
    always @(posedge clk) begin
        m   <= model_next(m, rst_n, logic_req, logic_addr, sol_ready, rsp_valid, rsp_data, cyc);
        cyc <= cyc + 64'd1;
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            n_checks++;
            if (busy === (m.phase != P_IDLE) && logic_ack === (m.phase == P_ACK) &&
                sol_valid === (m.phase == P_ISSUE) && sol_addr === m.addr &&
                logic_data === m.data && timeout_err === m.terr &&
                req_count === m.reqc && timeout_count === m.toc) begin
                n_pass++;
            end else begin
                $display("FAIL model_cycle %0d: dut busy=%b ack=%b sv=%b addr=%h data=%h terr=%b reqc=%0d toc=%0d | model phase=%0d addr=%h data=%h terr=%b reqc=%0d toc=%0d",
                         cyc, busy, logic_ack, sol_valid, sol_addr, logic_data, timeout_err,
                         req_count, timeout_count, m.phase, m.addr, m.data, m.terr, m.reqc, m.toc);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (logic_ack !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit got_ack;
        int drop;
        got_ack = 1'b0;
        drop    = 0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("rst_ack", logic_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sol_valid", sol_valid, 0);
        chk("rst_data", logic_data, 0);
        chk("rst_sol_addr", sol_addr, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_req_count", req_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
        rst_n = 1'b1;

        // Basic transaction
        logic_req = 1'b1; logic_addr = 32'h40; sol_ready = 1'b1;
        @(negedge clk);
        chk("basic_sol_valid", sol_valid, 1);
        chk("basic_sol_addr", sol_addr, 32'h40);
        @(negedge clk);
        chk("basic_valid_drop", sol_valid, 0);
        rsp_valid = 1'b1; rsp_data = 32'hABCD1234;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("basic_ack", logic_ack, 1);
        chk("basic_data", logic_data, 32'hABCD1234);
        chk("basic_req_count", req_count, 1);
        chk("basic_terr", timeout_err, 0);
        logic_req = 1'b0;
        @(negedge clk);
        chk("basic_ack_one_cycle", logic_ack, 0);
        @(negedge clk);
        chk("basic_back_idle", busy, 0);

        // Backpressure: five cycles without sol_ready
        sol_ready = 1'b0; logic_addr = 32'h12345678; logic_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sol_valid", sol_valid, 1);
            chk("bp_sol_addr", sol_addr, 32'h12345678);
            @(negedge clk);
        end
        chk("bp_valid_before_hs", sol_valid, 1);
        sol_ready = 1'b1;
        @(negedge clk);
        sol_ready = 1'b0;
        chk("bp_single_hs", sol_valid, 0);
        rsp_valid = 1'b1; rsp_data = 32'h0BADF00D;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("bp_ack", logic_ack, 1);
        chk("bp_data", logic_data, 32'h0BADF00D);
        chk("bp_terr", timeout_err, 0);
        logic_req = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout with no response
        sol_ready = 1'b1; logic_addr = 32'h80; logic_req = 1'b1;
        @(negedge clk);
        chk("to_issue", sol_valid, 1);
        wait_ack(20, n);
        chk("to_latency", n, T);
        chk("to_ack", logic_ack, 1);
        chk("to_data", logic_data, ERR);
        chk("to_terr", timeout_err, 1);
        chk("to_count", timeout_count, 1);
        logic_req = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h11111111;
        repeat (2) begin
            @(negedge clk);
            chk("to_late_rsp_no_ack", logic_ack, 0);
            chk("to_late_rsp_data", logic_data, ERR);
        end
        rsp_valid = 1'b0;

        // Response on the expiry cycle wins
        logic_addr = 32'hC0; logic_req = 1'b1; sol_ready = 1'b1;
        @(negedge clk);
        repeat (T - 1) @(negedge clk);
        chk("sim_no_early_ack", logic_ack, 0);
        rsp_valid = 1'b1; rsp_data = 32'h5A5A0F0F;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("sim_ack", logic_ack, 1);
        chk("sim_data", logic_data, 32'h5A5A0F0F);
        chk("sim_count_unchanged", timeout_count, 1);

        // Held request stays in DRAIN without a second ack
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("held_no_ack", logic_ack, 0);
        end
        chk("held_busy", busy, 1);
        chk("held_req_count", req_count, 4);
        logic_req = 1'b0;
        @(negedge clk);
        chk("held_release_idle", busy, 0);
        logic_req = 1'b1; logic_addr = 32'h100; sol_ready = 1'b1;
        @(negedge clk);
        chk("held_second_req_count", req_count, 5);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'h00002222;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("held_second_ack", logic_ack, 1);
        chk("held_second_data", logic_data, 32'h00002222);
        logic_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT
        logic_req = 1'b1; logic_addr = 32'h300; sol_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_in_wait", busy, 1);
        rst_n = 1'b0; logic_req = 1'b0;
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_data", logic_data, 0);
        chk("mr_sol_addr", sol_addr, 0);
        chk("mr_terr", timeout_err, 0);
        chk("mr_req_count", req_count, 0);
        chk("mr_timeout_count", timeout_count, 0);
        rst_n = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h33;
        repeat (3) begin
            @(negedge clk);
            chk("mr_rsp_no_ack", logic_ack, 0);
        end
        rsp_valid = 1'b0;

        // Randomized CPU and solver traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; logic_req = 1'b0; got_ack = 1'b0;
            end else begin
                rst_n = 1'b1;
                if (logic_req) begin
                    if (logic_ack) begin
                        got_ack = 1'b1;
                        drop    = int'($urandom_range(0, 3));
                    end
                    if (got_ack) begin
                        if (drop == 0) begin
                            logic_req = 1'b0; got_ack = 1'b0;
                        end else begin
                            drop--;
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    logic_req  = 1'b1;
                    logic_addr = $urandom;
                end
            end
            sol_ready = 1'($urandom_range(0, 1));
            rsp_valid = ($urandom_range(0, 5) == 0);
            rsp_data  = $urandom;
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
